// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : RV32I opcode constants, datapath default and immediate formats
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int c_xlen = 32;

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

endpackage
`default_nettype wire

// File: rtl/scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard
// Description : Per-register busy bits tracking in-flight register writers
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard #(
    parameter int NREG = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_reg,
    input  logic       wb_clr_en,
    input  logic [4:0] wb_clr_reg,
    input  logic       flush_clr_en,
    input  logic [4:0] flush_clr_reg,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] rd_addr,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Set is applied last so an issuing writer wins over a same-cycle clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_clr_en)    w_busy_nxt[wb_clr_reg]    = 1'b0;
        if (flush_clr_en) w_busy_nxt[flush_clr_reg] = 1'b0;
        if (set_en)       w_busy_nxt[set_reg]       = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign rs1_busy = r_busy[rs1_addr];
    assign rs2_busy = r_busy[rs2_addr];
    assign rd_busy  = r_busy[rd_addr];

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode with hazard scoreboard and ID/EX pipeline register
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = c_xlen,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_read_reg1,
    output logic [4:0]      rf_read_reg2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_reg,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_reg_write,
    output logic            ex_illegal
);

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic            w_legal;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_writes;
    logic            w_reg_write;
    imm_fmt_t        w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_rs1_busy;
    logic            w_rs2_busy;
    logic            w_rd_busy;
    logic            w_hazard;
    logic            w_fire;

    assign w_opcode     = if_instr[6:0];
    assign w_rd         = if_instr[11:7];
    assign rf_read_reg1 = if_instr[19:15];
    assign rf_read_reg2 = if_instr[24:20];

    always_comb begin
        w_legal    = (if_instr[1:0] == 2'b11);
        w_fmt      = IMM_NONE;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        w_writes   = 1'b1;
        case (w_opcode)
            c_opc_lui, c_opc_auipc: begin
                w_fmt      = IMM_U;
                w_rs1_used = 1'b0;
            end
            c_opc_jal: begin
                w_fmt      = IMM_J;
                w_rs1_used = 1'b0;
            end
            c_opc_jalr, c_opc_load, c_opc_op_imm: w_fmt = IMM_I;
            c_opc_branch: begin
                w_fmt      = IMM_B;
                w_rs2_used = 1'b1;
                w_writes   = 1'b0;
            end
            c_opc_store: begin
                w_fmt      = IMM_S;
                w_rs2_used = 1'b1;
                w_writes   = 1'b0;
            end
            c_opc_op: w_rs2_used = 1'b1;
            default:  w_legal    = 1'b0;
        endcase
        // Illegal encodings use no registers, so they can never stall.
        if (!w_legal) begin
            w_fmt      = IMM_NONE;
            w_rs1_used = 1'b0;
            w_rs2_used = 1'b0;
            w_writes   = 1'b0;
        end
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            IMM_I: w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            IMM_S: w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            IMM_B: w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25],
                            if_instr[11:8], 1'b0};
            IMM_U: w_imm = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
            IMM_J: w_imm = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20],
                            if_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign w_reg_write = w_writes && (w_rd != 5'd0);
    assign w_hazard    = w_legal && ((w_rs1_used && w_rs1_busy) ||
                                     (w_rs2_used && w_rs2_busy) ||
                                     (w_reg_write && w_rd_busy));
    assign if_ready    = !w_hazard && !flush && (!ex_valid || ex_ready);
    assign w_fire      = if_valid && if_ready;

    scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .set_en        (w_fire && w_reg_write),
        .set_reg       (w_rd),
        .wb_clr_en     (wb_valid),
        .wb_clr_reg    (wb_reg),
        .flush_clr_en  (flush && ex_valid && ex_reg_write),
        .flush_clr_reg (ex_rd),
        .rs1_addr      (rf_read_reg1),
        .rs2_addr      (rf_read_reg2),
        .rd_addr       (w_rd),
        .rs1_busy      (w_rs1_busy),
        .rs2_busy      (w_rs2_busy),
        .rd_busy       (w_rd_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7    <= '0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (w_fire) begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_rs1_data  <= rf_read_data1;
            ex_rs2_data  <= rf_read_data2;
            ex_imm       <= w_imm;
            ex_rd        <= w_rd;
            ex_opcode    <= w_opcode;
            ex_funct3    <= if_instr[14:12];
            ex_funct7    <= if_instr[31:25];
            ex_reg_write <= w_reg_write;
            ex_illegal   <= !w_legal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_read_reg1;
    logic [4:0]  rf_read_reg2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_reg_write;
    logic        ex_illegal;

    int r_checks   = 0;
    int r_failures = 0;

    logic [31:0] r_rf [32];

    always #5 clk = ~clk;

    // Register file model: combinational read, write at the edge ending wb_valid.
    assign rf_read_data1 = r_rf[rf_read_reg1];
    assign rf_read_data2 = r_rf[rf_read_reg2];

    always @(posedge clk) begin
        if (wb_valid && wb_reg != 5'd0) r_rf[wb_reg] <= wb_data;
    end

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .wb_valid      (wb_valid),
        .wb_reg        (wb_reg),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_pc         (ex_pc),
        .ex_rs1_data   (ex_rs1_data),
        .ex_rs2_data   (ex_rs2_data),
        .ex_imm        (ex_imm),
        .ex_rd         (ex_rd),
        .ex_opcode     (ex_opcode),
        .ex_funct3     (ex_funct3),
        .ex_funct7     (ex_funct7),
        .ex_reg_write  (ex_reg_write),
        .ex_illegal    (ex_illegal)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_failures++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] busy_vec();
        return 32'(dut.u_sb.r_busy);
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) r_rf[i] = 32'(i) * 32'h10;
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = 32'h0000_0013;
        if_pc    = 32'h0;
        wb_valid = 1'b0;
        wb_reg   = 5'd0;
        wb_data  = 32'h0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        tick();
        tick();
        check_val("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        check_val("rst_ex_imm", ex_imm, 32'h0);
        check_val("rst_ex_rd", {27'b0, ex_rd}, 32'h0);
        check_val("rst_busy", busy_vec(), 32'h0);
        rst = 1'b0;

        // addi x1,x0,5
        if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = 32'h100;
        #1 check_val("addi_ready", {31'b0, if_ready}, 32'h1);
        tick();
        check_val("addi_valid", {31'b0, ex_valid}, 32'h1);
        check_val("addi_rd", {27'b0, ex_rd}, 32'd1);
        check_val("addi_imm", ex_imm, 32'd5);
        check_val("addi_rw", {31'b0, ex_reg_write}, 32'h1);
        check_val("addi_pc", ex_pc, 32'h100);
        check_val("addi_busy", busy_vec(), 32'h2);

        // add x2,x1,x1 stalls on busy x1
        if_instr = 32'h0010_8133; if_pc = 32'h104;
        #1 check_val("raw_stall0", {31'b0, if_ready}, 32'h0);
        tick();
        check_val("raw_drained", {31'b0, ex_valid}, 32'h0);
        wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h55;
        #1 check_val("raw_stall_wb", {31'b0, if_ready}, 32'h0);
        tick();
        wb_valid = 1'b0;
        #1 check_val("raw_release", {31'b0, if_ready}, 32'h1);
        tick();
        check_val("add_valid", {31'b0, ex_valid}, 32'h1);
        check_val("add_rs1", ex_rs1_data, 32'h55);
        check_val("add_rs2", ex_rs2_data, 32'h55);
        check_val("add_opcode", {25'b0, ex_opcode}, 32'h33);
        check_val("add_busy", busy_vec(), 32'h4);

        // retire x2
        if_valid = 1'b0;
        wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h77;
        tick();
        wb_valid = 1'b0;

        // sw x2,8(x1); beq x0,x0,-4; lui x5,0x12345 back to back
        if_valid = 1'b1; if_instr = 32'h0020_A423; if_pc = 32'h108;
        #1 check_val("sw_ready", {31'b0, if_ready}, 32'h1);
        tick();
        check_val("sw_imm", ex_imm, 32'd8);
        check_val("sw_rw", {31'b0, ex_reg_write}, 32'h0);
        check_val("sw_rs2", ex_rs2_data, 32'h77);
        check_val("sw_funct3", {29'b0, ex_funct3}, 32'h2);
        check_val("sw_busy", busy_vec(), 32'h0);
        if_instr = 32'hFE00_0EE3; if_pc = 32'h10C;
        tick();
        check_val("beq_imm", ex_imm, 32'hFFFF_FFFC);
        check_val("beq_funct7", {25'b0, ex_funct7}, 32'h7F);
        if_instr = 32'h1234_52B7; if_pc = 32'h110;
        tick();
        check_val("lui_imm", ex_imm, 32'h1234_5000);
        check_val("lui_rd", {27'b0, ex_rd}, 32'd5);
        check_val("lui_busy", busy_vec(), 32'h20);

        // backpressure: addi x6,x0,7 waits while execute is stalled
        ex_ready = 1'b0; if_instr = 32'h0070_0313; if_pc = 32'h114;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("bp_ready", {31'b0, if_ready}, 32'h0);
            tick();
            check_val("bp_valid", {31'b0, ex_valid}, 32'h1);
            check_val("bp_imm", ex_imm, 32'h1234_5000);
            check_val("bp_pc", ex_pc, 32'h110);
        end
        ex_ready = 1'b1;
        #1 check_val("bp_release", {31'b0, if_ready}, 32'h1);
        tick();
        check_val("bp_rd6", {27'b0, ex_rd}, 32'd6);
        check_val("bp_imm7", ex_imm, 32'd7);
        if_instr = 32'h0090_0393; if_pc = 32'h118;
        tick();
        check_val("bp_rd7", {27'b0, ex_rd}, 32'd7);
        check_val("bp_valid7", {31'b0, ex_valid}, 32'h1);

        // WAW: addi x5,x0,1 while x5 busy
        if_instr = 32'h0010_0293;
        #1 check_val("waw_stall", {31'b0, if_ready}, 32'h0);
        tick();
        check_val("waw_drain", {31'b0, ex_valid}, 32'h0);

        // writer to x3 then flush
        if_instr = 32'h0010_0193; if_pc = 32'h11C;
        tick();
        check_val("x3_busy", busy_vec(), 32'h0000_00E8);
        flush = 1'b1; if_instr = 32'h0001_8413; if_pc = 32'h120;
        #1 check_val("flush_block", {31'b0, if_ready}, 32'h0);
        tick();
        flush = 1'b0;
        check_val("flush_valid", {31'b0, ex_valid}, 32'h0);
        check_val("flush_busy", busy_vec(), 32'h0000_00E0);
        #1 check_val("x3_reader_ready", {31'b0, if_ready}, 32'h1);
        tick();
        check_val("x3_reader_rd", {27'b0, ex_rd}, 32'd8);
        check_val("x3_reader_rs1", ex_rs1_data, 32'h30);

        // FENCE is unsupported
        if_instr = 32'h0000_000F; if_pc = 32'h124;
        #1 check_val("fence_ready", {31'b0, if_ready}, 32'h1);
        tick();
        check_val("fence_illegal", {31'b0, ex_illegal}, 32'h1);
        check_val("fence_rw", {31'b0, ex_reg_write}, 32'h0);
        check_val("fence_imm", ex_imm, 32'h0);
        check_val("pre_rst_busy", busy_vec(), 32'h0000_01E0);

        // reset mid-stream
        rst = 1'b1; if_instr = 32'h0050_0093;
        tick();
        rst = 1'b0; if_valid = 1'b0;
        check_val("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
        check_val("mid_rst_busy", busy_vec(), 32'h0);
        check_val("mid_rst_imm", ex_imm, 32'h0);
        check_val("mid_rst_illegal", {31'b0, ex_illegal}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV32I core, between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake, decodes fields and immediates, and drives the register file's combinational read ports. It holds the ID/EX pipeline register toward execute. A per-register busy scoreboard stalls RAW and WAW hazards until writeback has landed in the register file.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, architectural register count (x0 hard-wired zero)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  decode accepts this cycle (combinational)
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction address
- rf_read_reg1  out  5  rs1 address to register file (combinational from if_instr[19:15])
- rf_read_reg2  out  5  rs2 address (if_instr[24:20])
- rf_read_data1  in  XLEN  rs1 data, combinational from register file
- rf_read_data2  in  XLEN  rs2 data
- wb_valid  in  1  writeback commits a register write this cycle
- wb_reg  in  5  destination being written back
- flush  in  1  kill ID/EX contents (taken branch/jump from execute)
- ex_valid  out  1  ID/EX entry valid
- ex_ready  in  1  execute consumes the entry
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered operands
- ex_rd  out  5; ex_opcode  out  7; ex_funct3  out  3; ex_funct7  out  7
- ex_reg_write  out  1  instruction writes rd (0 when rd = x0)
- ex_illegal  out  1  unsupported encoding

## Operation
- Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Anything else, or instr[1:0] != 11: illegal.
- Immediates, sign-extended to XLEN: I (JALR/LOAD/OP-IMM), S, B, U (low 12 bits zero), J. Immediate is 0 for OP and illegal.
- rs1 used: all legal except LUI/AUIPC/JAL. rs2 used: OP/STORE/BRANCH. reg_write: all legal except STORE/BRANCH, forced 0 when rd = 0.
- Scoreboard busy[31:1]; x0 never busy.
- hazard = legal && ((rs1 used && busy[rs1]) || (rs2 used && busy[rs2]) || (reg_write && busy[rd])). Illegal instructions never hazard.
- if_ready = !hazard && !flush && (!ex_valid || ex_ready).
- fire = if_valid && if_ready.
- On fire, the ID/EX register loads the decoded fields and rf data, and ex_valid <= 1. If reg_write, busy[rd] <= 1.
- Without fire, ex_valid && ex_ready gives ex_valid <= 0. Otherwise ID/EX holds unchanged (stable under backpressure).
- wb_valid clears busy[wb_reg]. When the same cycle's fire sets that bit, the set wins.
- flush: ex_valid <= 0 and no fire. If ex_valid && ex_reg_write, also clear busy[ex_rd]. This is exact because WAW stalling guarantees a single in-flight writer per register.
- Reset: ex_valid = 0, all ex_* = 0, busy = 0. rst overrides every other input.

## Timing
- Decode-to-execute latency is 1 cycle: fire at edge N gives ex_valid from N+1.
- Throughput is 1 instruction/cycle with no hazard.
- No bypass: the register file writes at the edge ending the wb_valid cycle. A dependent instruction therefore still stalls during the wb_valid cycle and fires the cycle after.
- Back-to-back dependent ALU ops cost (cycles to writeback) + 1 of stall.
- if_ready, rf_read_reg1 and rf_read_reg2 are combinational. All ex_* outputs are registered.

## Structure
- Package riscv_pkg holds the opcode constants, the XLEN default and an immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
- One sub-module, scoreboard: NREG busy bits with set (issue rd), clear (wb), clear (flush) ports, and two read-lookup plus one rd-lookup combinational outputs.
- Decode and immediate generation stay inline.

## Test plan
- Issue addi x1,x0,5 (0x00500093), ex_ready=1: next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_reg_write=1; busy[1]=1.
- Issue add x2,x1,x1 (0x00108133) while busy[1]: if_ready=0. Pulse wb_valid/wb_reg=1: still stalled that cycle, fires the next, ex_rs1_data equals the new x1.
- Issue sw x2,8(x1) (0x0020A423): ex_imm=8, ex_reg_write=0, no busy bit set. Issue beq x0,x0,-4 (0xFE000EE3): ex_imm=0xFFFFFFFC. Issue lui x5,0x12345 (0x123452B7): ex_imm=0x12345000.
- Hold ex_ready=0 for 3 cycles with if_valid=1: if_ready=0 and all ex_* stable. Release: drains one per cycle.
- Issue writer to x3, then flush with ex_valid=1: ex_valid=0, busy[3]=0. A following reader of x3 fires without stall.
- Issue 0x0000000F (FENCE, unsupported): ex_illegal=1, ex_reg_write=0, no stall. Assert rst mid-stream with busy bits set: next cycle ex_valid=0, busy all 0.
